// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared widths, load funct3 encodings and writeback FSM states
//            for the writeback-stage register file.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_if
// Brief    : MEM/WB writeback, data-memory return, stall and decode read
//            signals of the writeback-stage register file.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_regfile_if;
  import core_pkg::*;

  // MEM/WB pipeline register
  logic [ADDR_W-1:0] rd_addr_in;
  logic [XLEN-1:0]   rd_in;
  logic              writeback_en_in;
  logic              writeback_from_mem_in;
  logic [2:0]        mem_funct3;
  logic [1:0]        mem_byte_off;
  // Data memory return
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_rvalid;
  // Stall / hazard
  logic              wb_stall;
  logic              load_pending;
  logic [ADDR_W-1:0] load_pending_rd;
  // Decode read ports
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  // Statistics
  logic [31:0]       retired_count;

  modport master (
    output rd_addr_in, rd_in, writeback_en_in, writeback_from_mem_in,
    output mem_funct3, mem_byte_off, mem_rdata, mem_rvalid,
    output rs1_addr, rs2_addr,
    input  wb_stall, load_pending, load_pending_rd,
    input  rs1_data, rs2_data, retired_count
  );

  modport slave (
    input  rd_addr_in, rd_in, writeback_en_in, writeback_from_mem_in,
    input  mem_funct3, mem_byte_off, mem_rdata, mem_rvalid,
    input  rs1_addr, rs2_addr,
    output wb_stall, load_pending, load_pending_rd,
    output rs1_data, rs2_data, retired_count
  );

endinterface
`default_nettype wire

// File: rtl/wb_regfile_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Brief    : Extracts a byte / halfword / word from an aligned memory word
//            and sign- or zero-extends it to XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
  import core_pkg::*;
(
  input  wire logic [2:0]      funct3,
  input  wire logic [1:0]      byte_off,
  input  wire logic [XLEN-1:0] rdata,
  output logic      [XLEN-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection; halfwords only look at the upper offset bit
  always_comb begin
    case (byte_off)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; unknown funct3 passes the raw word through
  always_comb begin
    case (funct3)
      F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Writeback stage: 32x32 architectural register file with ALU or
//            load-data commit, late-load stall FSM, bypassing read ports and
//            retired-writeback counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
  import core_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,     // asynchronous, active low
  wb_regfile_if.slave bus
);

  wb_state_t         r_state;
  logic [ADDR_W-1:0] r_pend_rd;
  logic [2:0]        r_pend_f3;
  logic [1:0]        r_pend_off;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic [31:0]       r_retired;

  logic              w_waiting;
  logic [2:0]        w_f3;
  logic [1:0]        w_off;
  logic [XLEN-1:0]   w_load_data;
  logic              w_commit;
  logic [ADDR_W-1:0] w_wr_rd;
  logic [XLEN-1:0]   w_wr_data;
  logic              w_wr_en;

  assign w_waiting = (r_state == WB_WAIT_MEM);

  // While waiting, the load shape comes from the latched fields, not upstream
  assign w_f3  = w_waiting ? r_pend_f3  : bus.mem_funct3;
  assign w_off = w_waiting ? r_pend_off : bus.mem_byte_off;

  load_extend u_load_extend (
    .funct3   (w_f3),
    .byte_off (w_off),
    .rdata    (bus.mem_rdata),
    .data     (w_load_data)
  );

  // Commit selection: a completing late load, or an IDLE ALU / ready load
  always_comb begin
    w_commit  = 1'b0;
    w_wr_rd   = bus.rd_addr_in;
    w_wr_data = bus.rd_in;
    if (w_waiting) begin
      w_commit  = bus.mem_rvalid;
      w_wr_rd   = r_pend_rd;
      w_wr_data = w_load_data;
    end else if (bus.writeback_en_in) begin
      w_commit  = !bus.writeback_from_mem_in || bus.mem_rvalid;
      w_wr_data = bus.writeback_from_mem_in ? w_load_data : bus.rd_in;
    end
  end

  // x0 never takes a write, so it also never bypasses
  assign w_wr_en = w_commit && (w_wr_rd != '0);

  // Stall holds only until data shows up; the write retires in that cycle
  assign bus.wb_stall        = w_waiting && !bus.mem_rvalid;
  assign bus.load_pending    = w_waiting && !bus.mem_rvalid;
  assign bus.load_pending_rd = r_pend_rd;
  assign bus.retired_count   = r_retired;

  // Read ports: x0 is zero, same-cycle commit is bypassed, else the array
  always_comb begin
    bus.rs1_data = r_regs[bus.rs1_addr];
    if (bus.rs1_addr == '0)
      bus.rs1_data = '0;
    else if (w_wr_en && (w_wr_rd == bus.rs1_addr))
      bus.rs1_data = w_wr_data;

    bus.rs2_data = r_regs[bus.rs2_addr];
    if (bus.rs2_addr == '0)
      bus.rs2_data = '0;
    else if (w_wr_en && (w_wr_rd == bus.rs2_addr))
      bus.rs2_data = w_wr_data;
  end

  // Writeback FSM: latch a late load's fields and wait for its data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= WB_IDLE;
      r_pend_rd  <= '0;
      r_pend_f3  <= '0;
      r_pend_off <= '0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (bus.writeback_en_in && bus.writeback_from_mem_in && !bus.mem_rvalid) begin
            r_state    <= WB_WAIT_MEM;
            r_pend_rd  <= bus.rd_addr_in;
            r_pend_f3  <= bus.mem_funct3;
            r_pend_off <= bus.mem_byte_off;
          end
        end
        WB_WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            r_state    <= WB_IDLE;
            r_pend_rd  <= '0;
            r_pend_f3  <= '0;
            r_pend_off <= '0;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  // Register array update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_rd] <= w_wr_data;
    end
  end

  // Retired-writeback counter; x0 commits count too, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_retired <= '0;
    else if (w_commit)
      r_retired <= r_retired + 32'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Directed self-checking bench for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
  import core_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.writeback_en_in       = 1'b0;
    bus.writeback_from_mem_in = 1'b0;
    bus.mem_rvalid            = 1'b0;
  endtask

  // Single-cycle load with data already valid
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] off, input logic [31:0] rdata);
    bus.writeback_en_in       = 1'b1;
    bus.writeback_from_mem_in = 1'b1;
    bus.rd_addr_in            = rd;
    bus.mem_funct3            = f3;
    bus.mem_byte_off          = off;
    bus.mem_rdata             = rdata;
    bus.mem_rvalid            = 1'b1;
    #1;
    check("load_no_stall", {31'd0, bus.wb_stall}, 32'd0);
    step();
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.rd_addr_in = '0;
    bus.rd_in = '0;
    bus.mem_funct3 = '0;
    bus.mem_byte_off = '0;
    bus.mem_rdata = '0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    idle_inputs();

    // Reset state
    #3;
    check("rst_stall",   {31'd0, bus.wb_stall}, 32'd0);
    check("rst_pending", {31'd0, bus.load_pending}, 32'd0);
    check("rst_pend_rd", {27'd0, bus.load_pending_rd}, 32'd0);
    check("rst_retired", bus.retired_count, 32'd0);
    bus.rs1_addr = 5'd5;
    #1;
    check("rst_x5", bus.rs1_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // 1: ALU write to x5 with bypass
    bus.writeback_en_in = 1'b1;
    bus.rd_addr_in = 5'd5;
    bus.rd_in = 32'hDEADBEEF;
    bus.rs1_addr = 5'd5;
    #1;
    check("x5_bypass", bus.rs1_data, 32'hDEADBEEF);
    step();
    idle_inputs();
    #1;
    check("x5_array", bus.rs1_data, 32'hDEADBEEF);
    check("retired_1", bus.retired_count, 32'd1);

    // 2: write to x0 is discarded but counted
    bus.writeback_en_in = 1'b1;
    bus.rd_addr_in = 5'd0;
    bus.rd_in = 32'h1234;
    bus.rs1_addr = 5'd0;
    #1;
    check("x0_bypass", bus.rs1_data, 32'd0);
    step();
    idle_inputs();
    #1;
    check("x0_array", bus.rs1_data, 32'd0);
    check("retired_2", bus.retired_count, 32'd2);

    // 3: load extraction variants
    do_load(5'd7,  F3_LB,  2'd3, 32'h80FFFF7F);
    do_load(5'd8,  F3_LBU, 2'd0, 32'h80FFFF7F);
    do_load(5'd10, F3_LH,  2'd2, 32'h80FFFF7F);
    do_load(5'd11, F3_LHU, 2'd3, 32'h80FFFF7F);
    bus.rs1_addr = 5'd7;  bus.rs2_addr = 5'd8;  #1;
    check("lb_off3",  bus.rs1_data, 32'hFFFFFF80);
    check("lbu_off0", bus.rs2_data, 32'h0000007F);
    bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11; #1;
    check("lh_off2",  bus.rs1_data, 32'hFFFF80FF);
    check("lhu_off3", bus.rs2_data, 32'h000080FF);
    check("retired_6", bus.retired_count, 32'd6);

    // 4: late LW to x9, upstream churn while waiting
    bus.writeback_en_in = 1'b1;
    bus.writeback_from_mem_in = 1'b1;
    bus.rd_addr_in = 5'd9;
    bus.mem_funct3 = F3_LW;
    bus.mem_byte_off = 2'd0;
    bus.mem_rvalid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      bus.writeback_from_mem_in = 1'b0;
      bus.rd_addr_in = 5'd3;
      bus.rd_in = $urandom;
      bus.mem_funct3 = F3_LB;
      bus.mem_byte_off = 2'd1;
      bus.mem_rdata = $urandom;
      #1;
      check("wait_stall",   {31'd0, bus.wb_stall}, 32'd1);
      check("wait_pending", {31'd0, bus.load_pending}, 32'd1);
      check("wait_pend_rd", {27'd0, bus.load_pending_rd}, 32'd9);
      step();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd3;
    #1;
    check("done_stall",  {31'd0, bus.wb_stall}, 32'd0);
    check("done_bypass", bus.rs1_data, 32'hCAFEF00D);
    step();
    idle_inputs();
    #1;
    check("x9_array",   bus.rs1_data, 32'hCAFEF00D);
    check("x3_ignored", bus.rs2_data, 32'd0);
    check("retired_7",  bus.retired_count, 32'd7);
    check("idle_stall", {31'd0, bus.wb_stall}, 32'd0);

    // 5: asynchronous reset during WAIT_MEM
    bus.writeback_en_in = 1'b1;
    bus.writeback_from_mem_in = 1'b1;
    bus.rd_addr_in = 5'd12;
    bus.mem_rvalid = 1'b0;
    step();
    idle_inputs();
    #1;
    check("r5_stall_before", {31'd0, bus.wb_stall}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("r5_stall",   {31'd0, bus.wb_stall}, 32'd0);
    check("r5_pending", {31'd0, bus.load_pending}, 32'd0);
    check("r5_pend_rd", {27'd0, bus.load_pending_rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("r5_retired", bus.retired_count, 32'd0);
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd9; #1;
    check("r5_x5", bus.rs1_data, 32'd0);
    check("r5_x9", bus.rs2_data, 32'd0);
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd12; #1;
    check("r5_x7",  bus.rs1_data, 32'd0);
    check("r5_x12", bus.rs2_data, 32'd0);

    // 6: en=0 with random upstream data changes nothing
    bus.writeback_en_in = 1'b1;
    bus.rd_addr_in = 5'd5;
    bus.rd_in = 32'h11111111;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      bus.rd_addr_in = 5'(i + 1);
      bus.rd_in = $urandom;
      bus.writeback_from_mem_in = 1'($urandom);
      bus.mem_rvalid = 1'($urandom);
      bus.mem_rdata = $urandom;
      step();
    end
    idle_inputs();
    bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6; #1;
    check("en0_x5", bus.rs1_data, 32'h11111111);
    check("en0_x6", bus.rs2_data, 32'd0);
    check("en0_retired", bus.retired_count, 32'd1);
    check("en0_stall", {31'd0, bus.wb_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
